// File: rtl/matrix_mem_responder.sv
// Word-array memory responder for matrixProcessor with a valid/ready host port.
// Processor reads every cycle; one shared write port, processor writes win.
module matrix_mem_responder #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH_LOG2 = 10,
    parameter logic [WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] readAddr,
    output logic [WIDTH-1:0] dataIn,
    input  logic [WIDTH-1:0] writeAddr,
    input  logic [WIDTH-1:0] writeData,
    input  logic             writeEn,
    input  logic             hostValid,
    output logic             hostReady,
    input  logic             hostWrite,
    input  logic [WIDTH-1:0] hostAddr,
    input  logic [WIDTH-1:0] hostWData,
    output logic             hostRValid,
    output logic [WIDTH-1:0] hostRData,
    output logic             addrErr,
    input  logic             clrErr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE,
        RESP
    } hostState_t;

    hostState_t state;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] rdOff;
    logic [WIDTH-1:0] wrOff;
    logic [WIDTH-1:0] hOff;

    logic rdOk;
    logic wrOk;
    logic hOk;

    logic [DEPTH_LOG2-1:0] rdIdx;
    logic [DEPTH_LOG2-1:0] wrIdx;
    logic [DEPTH_LOG2-1:0] hIdx;

    logic                  hostFire;
    logic                  pWrite;
    logic                  hWrite;
    logic                  memWe;
    logic [DEPTH_LOG2-1:0] memIdx;
    logic [WIDTH-1:0]      memWd;
    logic [WIDTH-1:0]      rdData;
    logic [WIDTH-1:0]      hRdData;
    logic                  errSet;

    // Offsets wrap at WIDTH bits, so addresses below BASE_ADDR land out of range.
    assign rdOff = readAddr - BASE_ADDR;
    assign wrOff = writeAddr - BASE_ADDR;
    assign hOff  = hostAddr - BASE_ADDR;

    assign rdOk = (rdOff[1:0] == 2'b00) && (rdOff[WIDTH-1:DEPTH_LOG2+2] == '0);
    assign wrOk = (wrOff[1:0] == 2'b00) && (wrOff[WIDTH-1:DEPTH_LOG2+2] == '0);
    assign hOk  = (hOff[1:0] == 2'b00) && (hOff[WIDTH-1:DEPTH_LOG2+2] == '0);

    assign rdIdx = rdOff[DEPTH_LOG2+1:2];
    assign wrIdx = wrOff[DEPTH_LOG2+1:2];
    assign hIdx  = hOff[DEPTH_LOG2+1:2];

    assign hostReady = (state == IDLE) && !writeEn;
    assign hostFire  = hostValid && hostReady;

    // hostReady already excludes writeEn, so at most one writer per cycle.
    assign pWrite = writeEn && wrOk;
    assign hWrite = hostFire && hostWrite && hOk;
    assign memWe  = pWrite || hWrite;
    assign memIdx = pWrite ? wrIdx : hIdx;
    assign memWd  = pWrite ? writeData : hostWData;

    assign rdData  = (memWe && (memIdx == rdIdx)) ? memWd : mem[rdIdx];
    assign hRdData = (memWe && (memIdx == hIdx)) ? memWd : mem[hIdx];

    assign errSet = !rdOk
                  || (writeEn && !wrOk)
                  || (hostFire && !hOk);

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memIdx] <= memWd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dataIn     <= '0;
            hostRData  <= '0;
            hostRValid <= 1'b0;
            addrErr    <= 1'b0;
        end else begin
            dataIn     <= rdOk ? rdData : '0;
            hostRValid <= 1'b0;
            addrErr    <= errSet || (addrErr && !clrErr);
            unique case (state)
                IDLE: begin
                    if (hostFire && !hostWrite) begin
                        state      <= RESP;
                        hostRValid <= 1'b1;
                        hostRData  <= hOk ? hRdData : '0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
